// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: FSM state encodings and the
// oversampling tick constants used by the receiver's counters.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  localparam int          OVERSAMPLE = 16;
  localparam logic [4:0]  MID_TICK   = 5'd7;                 // middle of the start bit
  localparam logic [4:0]  LAST_TICK  = 5'(OVERSAMPLE - 1);   // end of a full bit period

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset (both flops load RESET_VAL)
//   d_i    - asynchronous input
//   q_o    - synchronized output, 2 clk latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8-N-1 style UART receiver driven by a 16x oversampling tick. The start bit is
// qualified at its middle, data bits are sampled mid-bit LSB first, and the
// stop bit is checked at the end of SB_TICKS ticks.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   rx           - serial line (idles high, asynchronous to clk)
//   i_ticks      - one-clk pulse at 16x the baud rate
//   o_data_byte  - last received byte (held until the next frame completes)
//   o_rx_done    - one-clk pulse when a frame completes
//   o_frame_err  - stop bit was sampled low on the last frame
//   o_parity_err - parity mismatch on the last frame (UART_RX_PARITY_EN only)
// Build option: define UART_RX_PARITY_EN to add a parity bit between the data
// bits and the stop bit (PARITY_ODD selects odd parity).
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICKS   = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  i_ticks,
  output logic [DATA_WIDTH-1:0] o_data_byte,
  output logic                  o_rx_done,
`ifdef UART_RX_PARITY_EN
  output logic                  o_parity_err,
`endif
  output logic                  o_frame_err
);

  localparam int               NW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [NW-1:0]    N_LAST  = NW'(DATA_WIDTH - 1);
  localparam logic [4:0]       SB_LAST = 5'(SB_TICKS - 1);

  logic                  rx_s;
  state_t                state_q, state_d;
  logic [4:0]            s_cnt_q, s_cnt_d;
  logic [NW-1:0]         n_cnt_q, n_cnt_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Start edge is watched every clk so its phase is not quantised to ticks.
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (i_ticks) begin
          if (s_cnt_q == MID_TICK) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;       // too short to be a start bit
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_ticks) begin
          if (s_cnt_q == LAST_TICK) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DATA_WIDTH-1:1]};
            if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_ticks) begin
          if (s_cnt_q == LAST_TICK) begin
            s_cnt_d = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (i_ticks) begin
          if (s_cnt_q == SB_LAST) begin
            data_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^b_q ^ par_q ^ PARITY_ODD;
`endif
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data_byte = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. A bench-side serial driver plays the role of the
// transmitter; each driven frame pushes its expected result into a queue and a
// monitor pops and compares on every o_rx_done strobe. The tick period is kept
// short so the whole sequence stays within a small cycle budget.
// Build option: UART_RX_PARITY_EN adds a parity bit to every frame and the
// parity-error scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int TICK_DIV = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       i_ticks = 1'b0;
  logic [7:0] o_data_byte;
  logic       o_rx_done;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int errors = 0;
  // {parity_err, frame_err, data}
  logic [9:0] exp_q[$];

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .i_ticks      (i_ticks),
    .o_data_byte  (o_data_byte),
    .o_rx_done    (o_rx_done),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 i_ticks = 1'b1;
      @(posedge clk);
      #1 i_ticks = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (i_ticks !== 1'b1);
    end
  endtask

  task automatic drive_bit(input logic b, input int nticks);
    #1 rx = b;
    wait_ticks(nticks);
  endtask

  // stop_ticks < 16 lets a low stop bit end early so the receiver's re-entry
  // into START after the frame sees a high line and rejects it.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int stop_ticks);
    exp_q.push_back({^d ^ par, ~stop, d});
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, 16);
`endif
    drive_bit(stop, stop_ticks);
    #1 rx = 1'b1;
    wait_ticks(4);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (o_rx_done === 1'b1) begin
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("rx frame data=0x%02h frame_err=%0b", o_data_byte, o_frame_err);
          check("data_byte", 32'(o_data_byte), 32'(e[7:0]));
          check("frame_err", 32'(o_frame_err), 32'(e[8]));
`ifdef UART_RX_PARITY_EN
          check("parity_err", 32'(o_parity_err), 32'(e[9]));
`endif
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset_data", 32'(o_data_byte), 32'd0);
    check("reset_done", 32'(o_rx_done), 32'd0);
    check("reset_ferr", 32'(o_frame_err), 32'd0);
    reset = 1'b1;
    wait_ticks(4);

    // 1. Clean 0xAA
    send_frame(8'hAA, 1'b1, ^8'hAA, 16);
    wait_drain("drain_aa");

    // 2. Transmitter-style 0x55
    send_frame(8'h55, 1'b1, ^8'h55, 16);
    wait_drain("drain_55");

    // 3. Short low glitch: no strobe, outputs hold
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 16);
    check("glitch_data_hold", 32'(o_data_byte), 32'h55);
    check("glitch_ferr_hold", 32'(o_frame_err), 32'd0);
    check("glitch_no_frame", 32'(exp_q.size()), 32'd0);

    // 4. Bad stop bit on 0x3C, then clean 0x01 clears the flag
    send_frame(8'h3C, 1'b0, ^8'h3C, 12);
    wait_ticks(8);
    wait_drain("drain_3c");
    send_frame(8'h01, 1'b1, ^8'h01, 16);
    wait_drain("drain_01");

    // 5. Reset in the middle of data bit 3 of 0xF0
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 16);  // 0xF0 bits 0..2
    drive_bit(1'b0, 8);                               // half of bit 3
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_data", 32'(o_data_byte), 32'd0);
    check("midreset_done", 32'(o_rx_done), 32'd0);
    check("midreset_ferr", 32'(o_frame_err), 32'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_ticks(4);
    check("midreset_no_frame", 32'(exp_q.size()), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81, 16);
    wait_drain("drain_81");

`ifdef UART_RX_PARITY_EN
    // 6. Even parity on 0x07
    send_frame(8'h07, 1'b1, 1'b1, 16);
    wait_drain("drain_par_ok");
    send_frame(8'h07, 1'b1, 1'b0, 16);
    wait_drain("drain_par_bad");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
